// File: rtl/mcu_multicycle.sv
// mcu_multicycle: multicycle main control FSM for the MIPS32 core.
// Steps each instruction through fetch, decode, execute, memory and writeback
// states, waiting on the mem_ready handshake during memory accesses.
// It flags illegal opcodes and memory timeouts with sticky bits, and pulses
// instr_done once per retired instruction.
// Optional feature macro: MCU_IMM_EN (adds ADDI/ORI through IMMEX/IMMWB).
module mcu_multicycle #(
  parameter int OPCODE_LEN = 6,
  parameter int ALUOP_LEN  = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [OPCODE_LEN-1:0] OpCode,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  PCWriteCond,
  output logic [1:0]            PCSrc,
  output logic                  IorD,
  output logic                  MemRd,
  output logic                  MemWr,
  output logic                  IRWrite,
  output logic                  RegDst,
  output logic                  RegWr,
  output logic                  MemtoReg,
  output logic                  ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [ALUOP_LEN-1:0]  ALUOp,
  output logic                  instr_done,
  output logic                  illegal_op,
  output logic                  bus_err,
  output logic [3:0]            state_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IMMEX  = 4'd10,
    S_IMMWB  = 4'd11,
    S_TRAP   = 4'd15
  } state_e;

  localparam logic [OPCODE_LEN-1:0] OP_R   = OPCODE_LEN'(6'b000000);
  localparam logic [OPCODE_LEN-1:0] OP_LW  = OPCODE_LEN'(6'b100011);
  localparam logic [OPCODE_LEN-1:0] OP_SW  = OPCODE_LEN'(6'b101011);
  localparam logic [OPCODE_LEN-1:0] OP_BEQ = OPCODE_LEN'(6'b000100);
  localparam logic [OPCODE_LEN-1:0] OP_J   = OPCODE_LEN'(6'b000010);
`ifdef MCU_IMM_EN
  localparam logic [OPCODE_LEN-1:0] OP_ADDI = OPCODE_LEN'(6'b001000);
  localparam logic [OPCODE_LEN-1:0] OP_ORI  = OPCODE_LEN'(6'b001101);
`endif

  localparam logic [ALUOP_LEN-1:0] ALU_ADD   = ALUOP_LEN'(2'b00);
  localparam logic [ALUOP_LEN-1:0] ALU_SUB   = ALUOP_LEN'(2'b01);
  localparam logic [ALUOP_LEN-1:0] ALU_FUNCT = ALUOP_LEN'(2'b10);
`ifdef MCU_IMM_EN
  localparam logic [ALUOP_LEN-1:0] ALU_OR    = ALUOP_LEN'(2'b11);
`endif

  // Counter only needs to hold 0..TIMEOUT-1: the fault fires on the wait
  // cycle that would take it to TIMEOUT.
  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic            TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic             wait_st;

  // Next-state, wait-counter and sticky-flag logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    wait_st   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
        else           wait_st = 1'b1;
      end
      S_DECODE: begin
        case (OpCode)
          OP_R:          state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
`ifdef MCU_IMM_EN
          OP_ADDI, OP_ORI: state_d = S_IMMEX;
`endif
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready) state_d = S_MEMWB;
        else           wait_st = 1'b1;
      end
      S_MEMWR: begin
        if (mem_ready) state_d = S_FETCH;
        else           wait_st = 1'b1;
      end
      S_MEMWB, S_RWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
`ifdef MCU_IMM_EN
      S_IMMEX:  state_d = S_IMMWB;
      S_IMMWB:  state_d = S_FETCH;
`endif
      S_TRAP:   state_d = S_TRAP;
      default: begin
        state_d   = S_TRAP;
        illegal_d = 1'b1;
      end
    endcase
    // A ready on the final allowed cycle is handled above (no wait_st), so ready wins.
    if (wait_st && TO_EN) begin
      if (cnt_q == CNT_LAST) begin
        state_d   = S_TRAP;
        bus_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State, counter and sticky flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Control outputs decoded from the state; all forced low while reset is held.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSrc       = 2'b00;
    IorD        = 1'b0;
    MemRd       = 1'b0;
    MemWr       = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    RegWr       = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = ALU_ADD;
    instr_done  = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRd   = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        IorD  = 1'b1;
        MemRd = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWr      = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        MemWr      = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      S_RWB: begin
        RegDst     = 1'b1;
        RegWr      = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSrc       = 2'b01;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSrc      = 2'b10;
        instr_done = 1'b1;
      end
`ifdef MCU_IMM_EN
      S_IMMEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (OpCode == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_IMMWB: begin
        RegWr      = 1'b1;
        instr_done = 1'b1;
      end
`endif
      default: ;
    endcase
    if (!rst_n) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      PCSrc       = 2'b00;
      IorD        = 1'b0;
      MemRd       = 1'b0;
      MemWr       = 1'b0;
      IRWrite     = 1'b0;
      RegDst      = 1'b0;
      RegWr       = 1'b0;
      MemtoReg    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = ALU_ADD;
      instr_done  = 1'b0;
    end
  end

  assign illegal_op = illegal_q;
  assign bus_err    = bus_err_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_mcu_multicycle.sv
// Directed bench for mcu_multicycle: a per-cycle vector table plus hand-written
// sequences for asynchronous reset during a memory write.
module tb_mcu_multicycle;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] OpCode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRd, MemWr, IRWrite;
  logic       RegDst, RegWr, MemtoReg, ALUSrcA, instr_done, illegal_op, bus_err;
  logic [1:0] PCSrc, ALUSrcB, ALUOp;
  logic [3:0] state_o;

  mcu_multicycle #(.OPCODE_LEN(6), .ALUOP_LEN(2), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSrc(PCSrc), .IorD(IorD),
    .MemRd(MemRd), .MemWr(MemWr), .IRWrite(IRWrite), .RegDst(RegDst),
    .RegWr(RegWr), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .instr_done(instr_done), .illegal_op(illegal_op),
    .bus_err(bus_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, pcwc;
    logic [1:0] pcsrc;
    logic iord, mrd, mwr, irw, rdst, rwr, m2r, asa;
    logic [1:0] asb, aop;
    logic done, ill, berr;
  } obs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    obs_t       exp;
  } vec_t;

  localparam obs_t E_RST   = '{default: '0};
  localparam obs_t E_F0    = '{st: 4'd0, mrd: 1'b1, asb: 2'b01, default: '0};
  localparam obs_t E_F1    = '{st: 4'd0, mrd: 1'b1, asb: 2'b01, pcw: 1'b1, irw: 1'b1, default: '0};
  localparam obs_t E_DEC   = '{st: 4'd1, asb: 2'b11, default: '0};
  localparam obs_t E_MADR  = '{st: 4'd2, asa: 1'b1, asb: 2'b10, default: '0};
  localparam obs_t E_MRD   = '{st: 4'd3, iord: 1'b1, mrd: 1'b1, default: '0};
  localparam obs_t E_MWB   = '{st: 4'd4, m2r: 1'b1, rwr: 1'b1, done: 1'b1, default: '0};
  localparam obs_t E_MWR0  = '{st: 4'd5, iord: 1'b1, mwr: 1'b1, default: '0};
  localparam obs_t E_MWR1  = '{st: 4'd5, iord: 1'b1, mwr: 1'b1, done: 1'b1, default: '0};
  localparam obs_t E_EXEC  = '{st: 4'd6, asa: 1'b1, aop: 2'b10, default: '0};
  localparam obs_t E_RWB   = '{st: 4'd7, rdst: 1'b1, rwr: 1'b1, done: 1'b1, default: '0};
  localparam obs_t E_BR    = '{st: 4'd8, asa: 1'b1, aop: 2'b01, pcwc: 1'b1, pcsrc: 2'b01, done: 1'b1, default: '0};
  localparam obs_t E_JMP   = '{st: 4'd9, pcw: 1'b1, pcsrc: 2'b10, done: 1'b1, default: '0};
  localparam obs_t E_TILL  = '{st: 4'd15, ill: 1'b1, default: '0};
  localparam obs_t E_TBERR = '{st: 4'd15, berr: 1'b1, default: '0};
`ifdef MCU_IMM_EN
  localparam obs_t E_IADD  = '{st: 4'd10, asa: 1'b1, asb: 2'b10, aop: 2'b00, default: '0};
  localparam obs_t E_IORI  = '{st: 4'd10, asa: 1'b1, asb: 2'b10, aop: 2'b11, default: '0};
  localparam obs_t E_IWB   = '{st: 4'd11, rwr: 1'b1, done: 1'b1, default: '0};
`endif

  localparam logic [5:0] OPR = 6'b000000, OPLW = 6'b100011, OPSW = 6'b101011;
  localparam logic [5:0] OPBEQ = 6'b000100, OPJ = 6'b000010, OPBAD = 6'b111111;
  localparam logic [5:0] OPADDI = 6'b001000, OPORI = 6'b001101;

  obs_t act;
  assign act = {state_o, PCWrite, PCWriteCond, PCSrc, IorD, MemRd, MemWr, IRWrite,
                RegDst, RegWr, MemtoReg, ALUSrcA, ALUSrcB, ALUOp,
                instr_done, illegal_op, bus_err};

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input logic r, input logic [5:0] op, input logic rdy, input obs_t e);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then R-type with zero wait: 0,1,6,7
    add(0, OPR, 1, E_RST);
    add(0, OPR, 1, E_RST);
    add(1, OPR, 1, E_F1);   add(1, OPR, 1, E_DEC);  add(1, OPR, 1, E_EXEC); add(1, OPR, 1, E_RWB);
    // LW with three wait cycles in MEMRD
    add(1, OPLW, 1, E_F1);  add(1, OPLW, 1, E_DEC); add(1, OPLW, 1, E_MADR);
    add(1, OPLW, 0, E_MRD); add(1, OPLW, 0, E_MRD); add(1, OPLW, 0, E_MRD); add(1, OPLW, 1, E_MRD);
    add(1, OPLW, 1, E_MWB);
    // SW with one wait cycle in MEMWR
    add(1, OPSW, 1, E_F1);  add(1, OPSW, 1, E_DEC); add(1, OPSW, 1, E_MADR);
    add(1, OPSW, 0, E_MWR0); add(1, OPSW, 1, E_MWR1);
    // BEQ then J, 3 cycles each
    add(1, OPBEQ, 1, E_F1); add(1, OPBEQ, 1, E_DEC); add(1, OPBEQ, 1, E_BR);
    add(1, OPJ, 1, E_F1);   add(1, OPJ, 1, E_DEC);   add(1, OPJ, 1, E_JMP);
    // Ready arrives on the 15th FETCH cycle: no fault
    for (int unsigned i = 0; i < 14; i++) add(1, OPJ, 0, E_F0);
    add(1, OPJ, 1, E_F1);   add(1, OPJ, 1, E_DEC);   add(1, OPJ, 1, E_JMP);
    // 15 FETCH cycles without ready: bus error, TRAP holds until reset
    for (int unsigned i = 0; i < 15; i++) add(1, OPR, 0, E_F0);
    add(1, OPR, 1, E_TBERR); add(1, OPR, 1, E_TBERR);
    add(0, OPR, 1, E_RST);
    // Illegal opcode
    add(1, OPBAD, 1, E_F1); add(1, OPBAD, 1, E_DEC); add(1, OPBAD, 1, E_TILL); add(1, OPBAD, 1, E_TILL);
    add(0, OPR, 1, E_RST);
`ifdef MCU_IMM_EN
    add(1, OPADDI, 1, E_F1); add(1, OPADDI, 1, E_DEC); add(1, OPADDI, 1, E_IADD); add(1, OPADDI, 1, E_IWB);
    add(1, OPORI, 1, E_F1);  add(1, OPORI, 1, E_DEC);  add(1, OPORI, 1, E_IORI);  add(1, OPORI, 1, E_IWB);
`else
    add(1, OPADDI, 1, E_F1); add(1, OPADDI, 1, E_DEC); add(1, OPADDI, 1, E_TILL);
    add(0, OPR, 1, E_RST);
    add(1, OPORI, 1, E_F1);  add(1, OPORI, 1, E_DEC);  add(1, OPORI, 1, E_TILL);
    add(0, OPR, 1, E_RST);
`endif
    add(1, OPR, 1, E_F1);   add(1, OPR, 1, E_DEC);   add(1, OPR, 1, E_EXEC); add(1, OPR, 1, E_RWB);

    // Apply each vector just after a rising edge, check on the falling edge
    for (int unsigned i = 0; i < unsigned'(vecs.size()); i++) begin
      rst_n = vecs[i].rst; OpCode = vecs[i].op; mem_ready = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(act), 32'(vecs[i].exp));
      @(posedge clk); #1;
    end

    // Async reset while in MEMWR: strobes drop at once, no retire pulse
    rst_n = 1'b1; OpCode = OPSW; mem_ready = 1'b1;   // now in FETCH
    @(posedge clk); #1;                              // DECODE
    @(posedge clk); #1;                              // MEMADR
    mem_ready = 1'b0;
    @(posedge clk); #2;                              // MEMWR, waiting
    check("memwr_before_rst", {28'd0, state_o}, 32'd5);
    check("memwr_strobe", {31'd0, MemWr}, 32'd1);
    rst_n = 1'b0; #1;
    check("memwr_async_off", {29'd0, MemWr, MemRd, instr_done}, 32'd0);
    check("state_async_rst", {28'd0, state_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_ready = 1'b1; OpCode = OPR;
    @(negedge clk);
    check("fetch_after_rst", 32'(act), 32'(E_F1));
    @(posedge clk); #1;
    @(negedge clk);
    check("decode_after_rst", 32'(act), 32'(E_DEC));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
